// File: rtl/pio_debounced_in_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
// Latency: wires only; readdata is registered inside the slave.
// Backpressure: none, the slave accepts every access in a single clock.
interface pio_debounced_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_debounced_in.sv
// Debounced input PIO: synchroniser, per-bit debounce, edge capture, masked irq.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES clocks to stable; capture +1; readdata 1 clock.
// Backpressure: none; every bus access completes in one clock, no wait states.
module pio_debounced_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  pio_debounced_in_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [1:0]       edge_mode_q;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] edge_capture_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  // Only the low WIDTH (or 2) bits of writedata carry meaning.
  assign unused_bits = ^bus.writedata;

  assign wr_en  = bus.chipselect && !bus.write_n;
  assign synced = sync_q[SYNC_STAGES-1];

  // Multi-flop synchroniser chain for the raw asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES clocks; any return restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          stable_q[i] <= synced[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge selection from the debounced level and its one-clock-old copy.
  always_comb begin
    rise = stable_q & ~stable_d;
    fall = ~stable_q & stable_d;
    case (edge_mode_q)
      2'd1:    ev = fall;
      2'd2:    ev = rise | fall;
      default: ev = rise;
    endcase
  end

  assign clr = (wr_en && bus.address == ADDR_CAPT) ? bus.writedata[WIDTH-1:0] : '0;

  // Control registers and edge capture; a same-clock event beats a W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d       <= '0;
      edge_mode_q    <= 2'd0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      stable_d       <= stable_q;
      edge_capture_q <= (edge_capture_q & ~clr) | ev;
      if (wr_en && bus.address == ADDR_MODE) edge_mode_q <= bus.writedata[1:0];
      if (wr_en && bus.address == ADDR_MASK) irq_mask_q  <= bus.writedata[WIDTH-1:0];
    end
  end

  // Read mux, zero-extended to the 32-bit bus.
  always_comb begin
    rd_mux = 32'd0;
    case (bus.address)
      ADDR_DATA: rd_mux = 32'(stable_q);
      ADDR_MODE: rd_mux = 32'(edge_mode_q);
      ADDR_MASK: rd_mux = 32'(irq_mask_q);
      ADDR_CAPT: rd_mux = 32'(edge_capture_q);
      default:   rd_mux = 32'd0;
    endcase
  end

  // readdata is re-registered every clock, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= 32'd0;
    else          bus.readdata <= rd_mux;
  end

  assign bus.irq = |(edge_capture_q & irq_mask_q);

endmodule
